// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and types for the multdiv carry-lookahead adder.
package multdiv_pkg;

  localparam int DEFAULT_WIDTH            = 32;
  localparam int DEFAULT_GROUP            = 8;
  localparam int DEFAULT_GROUPS_PER_STAGE = 2;

  // Flag bundle registered alongside the final sum.
  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } cla_flags_t;

  // Number of pipeline stages: lookahead groups divided into stage-sized chunks, rounded up.
  function automatic int calcStages(input int width, input int group, input int groupsPerStage);
    return ((width / group) + groupsPerStage - 1) / groupsPerStage;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group_gp.sv
// One GROUP-bit lookahead group: per-bit sums plus group generate/propagate.
module cla_group_gp #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic [GROUP-1:0] g,
  input  logic [GROUP-1:0] p,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             group_g,
  output logic             group_p
);

  logic [GROUP-1:0] w_carry;

  // Carry into each bit of the group, derived from the bit generate/propagate terms.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = cin;
    for (int i = 0; i < GROUP - 1; i++) begin
      w_carry[i+1] = g[i] | (p[i] & w_carry[i]);
    end
  end

  // Group generate: carry out of the group assuming no carry in.
  always_comb begin
    group_g = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      group_g = g[i] | (p[i] & group_g);
    end
  end

  assign group_p = &p;
  assign sum     = a ^ b ^ w_carry;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves GROUPS_PER_STAGE lookahead groups and hands the carry,
// the finished low sum bits and the still-unprocessed upper operand bits on.
module pipelined_cla_adder
  import multdiv_pkg::*;
#(
  parameter int WIDTH            = DEFAULT_WIDTH,
  parameter int GROUP            = DEFAULT_GROUP,
  parameter int GROUPS_PER_STAGE = DEFAULT_GROUPS_PER_STAGE
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NG     = WIDTH / GROUP;
  localparam int STAGES = calcStages(WIDTH, GROUP, GROUPS_PER_STAGE);

  logic [STAGES-1:0] r_valid;
  logic              w_inReady;
  logic [WIDTH-1:0]  w_bEff;
  logic              w_c0;
  logic [WIDTH-1:0]  w_lastSum;
  cla_flags_t        w_lastFlags;
  logic              w_lastLoad;
  logic [WIDTH-1:0]  r_outSum;
  cla_flags_t        r_outFlags;

  // One global stall: the whole pipe freezes while the result waits for the consumer.
  assign w_inReady = ~r_valid[STAGES-1] | out_ready;
  assign in_ready  = w_inReady;

  // Subtraction is A + ~B + 1, so the carry-in is forced high.
  assign w_bEff = in_sub ? ~in_b : in_b;
  assign w_c0   = in_sub ? 1'b1 : in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int FIRST    = k * GROUPS_PER_STAGE;
    localparam int LAST     = ((k + 1) * GROUPS_PER_STAGE < NG) ? (k + 1) * GROUPS_PER_STAGE - 1 : NG - 1;
    localparam int NGRP     = LAST - FIRST + 1;
    localparam int INBITS   = WIDTH - FIRST * GROUP;
    localparam int NEWBITS  = NGRP * GROUP;
    localparam int DONEBITS = (LAST + 1) * GROUP;

    logic [INBITS-1:0]   w_a;
    logic [INBITS-1:0]   w_b;
    logic                w_cin;
    logic                w_signA;
    logic                w_signB;
    logic                w_load;
    logic [NEWBITS-1:0]  w_sumNew;
    logic [DONEBITS-1:0] w_sumAll;
    logic [NGRP:0]       w_carry;
    logic [NGRP-1:0]     w_grpG;
    logic [NGRP-1:0]     w_grpP;

    if (k == 0) begin : g_src
      assign w_a      = in_a;
      assign w_b      = w_bEff;
      assign w_cin    = w_c0;
      assign w_signA  = in_a[WIDTH-1];
      assign w_signB  = w_bEff[WIDTH-1];
      assign w_load   = w_inReady & in_valid;
      assign w_sumAll = w_sumNew;
    end else begin : g_src
      assign w_a      = g_stage[k-1].g_pipe.r_a;
      assign w_b      = g_stage[k-1].g_pipe.r_b;
      assign w_cin    = g_stage[k-1].g_pipe.r_carry;
      assign w_signA  = g_stage[k-1].g_pipe.r_signA;
      assign w_signB  = g_stage[k-1].g_pipe.r_signB;
      assign w_load   = w_inReady & r_valid[k-1];
      assign w_sumAll = {w_sumNew, g_stage[k-1].g_pipe.r_sum};
    end

    assign w_carry[0] = w_cin;

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
      cla_group_gp #(
        .GROUP(GROUP)
      ) u_group (
        .a      (w_a[j*GROUP +: GROUP]),
        .b      (w_b[j*GROUP +: GROUP]),
        .g      (w_a[j*GROUP +: GROUP] & w_b[j*GROUP +: GROUP]),
        .p      (w_a[j*GROUP +: GROUP] | w_b[j*GROUP +: GROUP]),
        .cin    (w_carry[j]),
        .sum    (w_sumNew[j*GROUP +: GROUP]),
        .group_g(w_grpG[j]),
        .group_p(w_grpP[j])
      );
      assign w_carry[j+1] = w_grpG[j] | (w_grpP[j] & w_carry[j]);
    end

    if (k < STAGES - 1) begin : g_pipe
      localparam int REM = WIDTH - DONEBITS;

      logic [REM-1:0]      r_a;
      logic [REM-1:0]      r_b;
      logic [DONEBITS-1:0] r_sum;
      logic                r_carry;
      logic                r_signA;
      logic                r_signB;

      // Stage register: finished low sum bits, stage carry, remaining upper operand bits.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_a     <= '0;
          r_b     <= '0;
          r_sum   <= '0;
          r_carry <= 1'b0;
          r_signA <= 1'b0;
          r_signB <= 1'b0;
        end else if (w_load) begin
          r_a     <= w_a[INBITS-1:NEWBITS];
          r_b     <= w_b[INBITS-1:NEWBITS];
          r_sum   <= w_sumAll;
          r_carry <= w_carry[NGRP];
          r_signA <= w_signA;
          r_signB <= w_signB;
        end
      end
    end else begin : g_last
      assign w_lastSum        = w_sumAll;
      assign w_lastFlags.cout = w_carry[NGRP];
      assign w_lastFlags.ovf  = (w_signA == w_signB) & (w_sumAll[DONEBITS-1] != w_signA);
      assign w_lastFlags.zero = ~|w_sumAll;
      assign w_lastLoad       = w_load;
    end
  end

  // Valid bits shift forward whenever the pipe is not stalled; empty slots travel as bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (w_inReady) begin
      r_valid[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  // Result register: full sum and flags, held while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_outSum   <= '0;
      r_outFlags <= '0;
    end else if (w_lastLoad) begin
      r_outSum   <= w_lastSum;
      r_outFlags <= w_lastFlags;
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_sum   = r_outSum;
  assign out_cout  = r_outFlags.cout;
  assign out_ovf   = r_outFlags.ovf;
  assign out_zero  = r_outFlags.zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: default 32-bit instance plus a
// 16-bit, one-group-per-stage instance.
module tb_pipelined_cla_adder;

  localparam int W = 32;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          inValid   = 1'b0;
  logic          inReady;
  logic [W-1:0]  inA       = '0;
  logic [W-1:0]  inB       = '0;
  logic          inSub     = 1'b0;
  logic          inCin     = 1'b0;
  logic          outValid;
  logic          outReady  = 1'b1;
  logic [W-1:0]  outSum;
  logic          outCout;
  logic          outOvf;
  logic          outZero;

  logic          inValid16 = 1'b0;
  logic          inReady16;
  logic [15:0]   inA16     = '0;
  logic [15:0]   inB16     = '0;
  logic          inSub16   = 1'b0;
  logic          inCin16   = 1'b0;
  logic          outValid16;
  logic [15:0]   outSum16;
  logic          outCout16;
  logic          outOvf16;
  logic          outZero16;

  pipelined_cla_adder dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(inValid), .in_ready(inReady), .in_a(inA), .in_b(inB),
    .in_sub(inSub), .in_cin(inCin),
    .out_valid(outValid), .out_ready(outReady), .out_sum(outSum),
    .out_cout(outCout), .out_ovf(outOvf), .out_zero(outZero)
  );

  pipelined_cla_adder #(.WIDTH(16), .GROUP(8), .GROUPS_PER_STAGE(1)) dut16 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(inValid16), .in_ready(inReady16), .in_a(inA16), .in_b(inB16),
    .in_sub(inSub16), .in_cin(inCin16),
    .out_valid(outValid16), .out_ready(1'b1), .out_sum(outSum16),
    .out_cout(outCout16), .out_ovf(outOvf16), .out_zero(outZero16)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          issued;
  } exp_t;

  exp_t sbQueue[$];
  int   total = 0;
  int   bad = 0;
  int   cycleCount = 0;
  int   emitted = 0;
  int   accepted = 0;
  bit   checkLat = 1'b0;

  always @(posedge clock) cycleCount++;

  // Reference: plain modular arithmetic on integers; overflow means the signed result leaves range.
  function automatic exp_t refModel(int w, longint a, longint b, bit sub, bit cin);
    exp_t   e;
    longint modulus = 64'sd1 <<< w;
    longint half    = modulus / 2;
    longint sa      = (a >= half) ? a - modulus : a;
    longint sb      = (b >= half) ? b - modulus : b;
    longint full;
    longint sres;
    if (sub) begin
      full   = a - b;
      e.cout = (a >= b);
      sres   = sa - sb;
    end else begin
      full   = a + b + longint'(cin);
      e.cout = (full >= modulus);
      sres   = sa + sb + longint'(cin);
    end
    if (full < 0) full = full + modulus;
    full     = full % modulus;
    e.sum    = full[31:0];
    e.ovf    = (sres >= half) || (sres < -half);
    e.zero   = (full == 0);
    e.issued = 0;
    return e;
  endfunction

  task automatic checkOutput(string name, longint actual, longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one operation and hold it until accepted; expected result goes to the scoreboard.
  task automatic applyStimulus(logic [31:0] a, logic [31:0] b, logic sub, logic cin);
    exp_t e;
    int   waitCycles = 0;
    bit   done = 1'b0;
    inA = a; inB = b; inSub = sub; inCin = cin; inValid = 1'b1;
    while (!done) begin
      @(negedge clock);
      if (inReady === 1'b1) begin
        e = refModel(W, longint'(a), longint'(b), sub, cin);
        e.issued = cycleCount;
        sbQueue.push_back(e);
        accepted++;
        done = 1'b1;
      end else begin
        waitCycles++;
        if (waitCycles > 50) begin
          total++; bad++;
          $display("[TB] FAIL accept_timeout: got in_ready=%0b expected 1", inReady);
          done = 1'b1;
        end
      end
      @(posedge clock); #1;
    end
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbQueue.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    checkOutput("drain_pending", sbQueue.size(), 0);
  endtask

  // Single directed operation on the 16-bit instance with latency measurement.
  task automatic check16(logic [15:0] a, logic [15:0] b, logic sub, logic cin);
    exp_t e;
    int   lat = 1;
    e = refModel(16, longint'(a), longint'(b), sub, cin);
    inA16 = a; inB16 = b; inSub16 = sub; inCin16 = cin; inValid16 = 1'b1;
    @(negedge clock);
    checkOutput("w16_in_ready", inReady16, 1);
    @(posedge clock); #1;
    inValid16 = 1'b0;
    while (outValid16 !== 1'b1 && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    checkOutput("w16_latency", lat, 2);
    checkOutput("w16_sum", outSum16, e.sum);
    checkOutput("w16_cout", outCout16, e.cout);
    checkOutput("w16_ovf", outOvf16, e.ovf);
    checkOutput("w16_zero", outZero16, e.zero);
    @(posedge clock); #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and watches stall behaviour.
  logic [31:0] heldSum = '0;
  bit          holding = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      holding = 1'b0;
    end else begin
      if (holding) begin
        checkOutput("stall_valid_held", outValid, 1);
        checkOutput("stall_sum_held", outSum, heldSum);
      end
      if (outValid === 1'b1 && !outReady) checkOutput("stall_in_ready", inReady, 0);
      if (outReady) checkOutput("in_ready_open", inReady, 1);
      if (outValid === 1'b1 && outReady) begin
        if (sbQueue.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_output: got sum 0x%0h expected no result", outSum);
        end else begin
          e = sbQueue.pop_front();
          emitted++;
          checkOutput("sum", outSum, e.sum);
          checkOutput("cout", outCout, e.cout);
          checkOutput("ovf", outOvf, e.ovf);
          checkOutput("zero", outZero, e.zero);
          if (checkLat) checkOutput("latency", cycleCount - e.issued, 2);
        end
      end
      holding = (outValid === 1'b1) && !outReady;
      heldSum = outSum;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    $display("[TB] start");
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_out_sum", outSum, 0);
    checkOutput("reset_out_cout", outCout, 0);
    checkOutput("reset_out_ovf", outOvf, 0);
    checkOutput("reset_out_zero", outZero, 0);
    checkOutput("reset_out_valid16", outValid16, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    $display("[TB] directed corner cases");
    checkLat = 1'b1;
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
    drain();

    $display("[TB] random back-to-back stream");
    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("[TB] stream with consumer backpressure");
    checkLat = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          outReady = pattern[i % 4];
          @(posedge clock); #1;
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
    join
    outReady = 1'b1;
    drain();
    checkLat = 1'b1;

    $display("[TB] reset with operations in flight");
    applyStimulus(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
    applyStimulus(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_async_drop", outValid, 0);
    accepted = accepted - sbQueue.size();
    sbQueue.delete();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_hold_valid", outValid, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    applyStimulus(32'd3, 32'd4, 1'b0, 1'b0);
    drain();

    $display("[TB] 16-bit instance, one group per stage");
    check16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    checkOutput("op_count", emitted, accepted);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
